// File: rtl/uart_tap_pkg.sv
// Shared types and constants for the UART tap receiver: FSM states, oversampling constants, baud divider.
// Pure declarations; no latency or backpressure of its own.
package uart_tap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    HOLD
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Rounded clocks-per-tick for 16x oversampling, never below 1.
  function automatic int tick_div(input longint clk_hz, input longint baud);
    longint d;
    d = (clk_hz + baud * 8) / (baud * 16);
    if (d < 1) d = 1;
    return int'(d);
  endfunction

endpackage

// File: rtl/uart_tap_fifo.sv
// Single-clock FWFT FIFO: head word visible on pop_dat while empty=0, zero when empty.
// Latency: a push becomes visible the next cycle; push while full is accepted only alongside a pop.
module uart_tap_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop_rdy & ~empty;
  assign do_push = push_vld & (~full | do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_tap_rx.sv
// 16x-oversampled 8N1 receiver (8E1 with parity_err when UART_TAP_RX_PARITY_EN is defined) feeding an FWFT FIFO.
// Byte visible two cycles after the stop-bit decision; full FIFO with rx_ready=0 drops the byte and pulses overrun_err.
module uart_tap_rx
  import uart_tap_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          uart_0_external_connection_txd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun_err,
`ifdef UART_TAP_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = tick_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]            sync;
  logic                  s;
  logic                  s_prev;
  rx_state_t             state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  tick;
  logic [3:0]            sc, sc_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]  shreg, shreg_n;
  logic [1:0]            samp, samp_n;
  logic [3:0]            hold_cnt, hold_cnt_n;
  logic                  push_vld, push_vld_n;
  logic [DATA_BITS-1:0]  push_dat, push_dat_n;
  logic                  frame_err_n;
  logic                  maj;
  logic                  mid;
  logic                  wrap;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
`ifdef UART_TAP_RX_PARITY_EN
  logic                  par_bad, par_bad_n;
  logic                  parity_err_n;
`endif

  assign s    = sync[1];
  assign tick = (cnt == CW'(DIV - 1));
  assign maj  = (samp[0] & samp[1]) | (samp[0] & s) | (samp[1] & s);
  // Third of the three mid-bit samples arrives one tick after MID_SAMPLE.
  assign mid  = tick && (sc == 4'(MID_SAMPLE + 1));
  assign wrap = tick && (sc == 4'(OVERSAMPLE - 1));

  always_comb begin
    state_n     = state;
    cnt_n       = tick ? '0 : cnt + CW'(1);
    sc_n        = tick ? sc + 4'd1 : sc;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    samp_n      = samp;
    hold_cnt_n  = hold_cnt;
    push_vld_n  = 1'b0;
    push_dat_n  = push_dat;
    frame_err_n = 1'b0;
`ifdef UART_TAP_RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    if (tick && sc == 4'(MID_SAMPLE - 1)) samp_n[0] = s;
    if (tick && sc == 4'(MID_SAMPLE))     samp_n[1] = s;

    case (state)
      IDLE: begin
        sc_n = '0;
        if (s_prev && !s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (mid && maj) begin
          state_n = IDLE;
        end else if (wrap) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (mid) shreg_n = {maj, shreg[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TAP_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
`ifdef UART_TAP_RX_PARITY_EN
        if (mid) par_bad_n = ((^shreg) != maj);
`endif
        if (wrap) state_n = STOP;
      end
      STOP: begin
        if (mid) begin
`ifdef UART_TAP_RX_PARITY_EN
          parity_err_n = par_bad;
`endif
          if (maj) begin
            push_vld_n = 1'b1;
            push_dat_n = shreg;
            state_n    = IDLE;
          end else begin
            frame_err_n = 1'b1;
            hold_cnt_n  = '0;
            state_n     = HOLD;
          end
        end
      end
      HOLD: begin
        // Stay here until the line has been high for a full bit time (covers breaks).
        if (tick) begin
          if (!s)
            hold_cnt_n = '0;
          else if (hold_cnt == 4'(OVERSAMPLE - 1))
            state_n = IDLE;
          else
            hold_cnt_n = hold_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync        <= 2'b11;
      s_prev      <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      sc          <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      samp        <= '0;
      hold_cnt    <= '0;
      push_vld    <= 1'b0;
      push_dat    <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_TAP_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], uart_0_external_connection_txd};
      s_prev      <= s;
      state       <= state_n;
      cnt         <= cnt_n;
      sc          <= sc_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      samp        <= samp_n;
      hold_cnt    <= hold_cnt_n;
      push_vld    <= push_vld_n;
      push_dat    <= push_dat_n;
      frame_err   <= frame_err_n;
      overrun_err <= push_vld & fifo_full & ~pop;
`ifdef UART_TAP_RX_PARITY_EN
      par_bad     <= par_bad_n;
      parity_err  <= parity_err_n;
`endif
    end
  end

  assign rx_valid = ~fifo_empty;
  assign pop      = rx_valid & rx_ready;

  uart_tap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (rx_ready),
    .pop_dat  (rx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_uart_tap_rx.sv
// Scoreboarded bench for uart_tap_rx at 16 clocks per bit; expected bytes queued by stimulus, checked by a monitor.
module tb_uart_tap_rx;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic [4:0] fifo_level;
`ifdef UART_TAP_RX_PARITY_EN
  logic       parity_err;
  logic       bad_par = 1'b0;
  int         n_par = 0;
`endif

  int         total = 0;
  int         bad = 0;
  int         n_frame = 0;
  int         n_ovr = 0;
  logic [7:0] exp_q [$];

  always #5 clk_clk = ~clk_clk;

  uart_tap_rx #(
    .CLK_HZ     (1843200),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_clk                        (clk_clk),
    .reset_reset                    (reset_reset),
    .uart_0_external_connection_txd (line),
    .rx_data                        (rx_data),
    .rx_valid                       (rx_valid),
    .rx_ready                       (rx_ready),
    .frame_err                      (frame_err),
    .overrun_err                    (overrun_err),
`ifdef UART_TAP_RX_PARITY_EN
    .parity_err                     (parity_err),
`endif
    .fifo_level                     (fifo_level)
  );

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    line = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_clk(16);
    end
`ifdef UART_TAP_RX_PARITY_EN
    line = (^b) ^ bad_par;
    wait_clk(16);
`endif
    line = stop_bit;
    wait_clk(16);
    line = 1'b1;
    wait_clk(16);
  endtask

  // Monitor: compares every accepted byte against the scoreboard and counts error pulses.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (rx_valid && rx_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_data unexpected byte got=%0h", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            bad++;
            $display("FAIL rx_data got=%0h want=%0h", rx_data, e);
          end
        end
      end
      if (frame_err)   n_frame++;
      if (overrun_err) n_ovr++;
`ifdef UART_TAP_RX_PARITY_EN
      if (parity_err)  n_par++;
`endif
    end
  end

  initial begin
    int f0;
    int o0;
    reset_reset = 1'b1;
    line        = 1'b1;
    rx_ready    = 1'b0;
    wait_clk(3);
    reset_reset = 1'b0;
    wait_clk(2);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun_err", overrun_err, 0);

    // Two back-to-back bytes, consumer always ready.
    rx_ready = 1'b1;
    wait_clk(20);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1);
    wait_clk(20);
    check("basic drained", exp_q.size(), 0);
    check("basic frame_err count", n_frame, 0);
    check("basic overrun count", n_ovr, 0);

    // Short low glitch must not start a frame.
    line = 1'b0;
    wait_clk(4);
    line = 1'b1;
    wait_clk(40);
    check("glitch fifo_level", fifo_level, 0);
    check("glitch rx_valid", rx_valid, 0);
    check("glitch frame_err count", n_frame, 0);

    // Bad stop bit, then line idle for 20 bit times.
    f0 = n_frame;
    line = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      line = 8'h3C >> i;
      wait_clk(16);
    end
`ifdef UART_TAP_RX_PARITY_EN
    line = ^8'h3C;
    wait_clk(16);
`endif
    line = 1'b0;
    wait_clk(16);
    line = 1'b1;
    wait_clk(20 * 16);
    check("stop-low frame_err count", n_frame - f0, 1);
    check("stop-low fifo_level", fifo_level, 0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    wait_clk(20);
    check("after frame error drained", exp_q.size(), 0);

    // Fill the FIFO with the consumer stalled; 17th byte overruns.
    rx_ready = 1'b0;
    o0 = n_ovr;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    wait_clk(10);
    check("fill level 16", fifo_level, 16);
    check("fill no overrun yet", n_ovr - o0, 0);
    send_byte(8'h10, 1'b1);
    wait_clk(10);
    check("overrun count on 0x10", n_ovr - o0, 1);
    check("overrun level stays 16", fifo_level, 16);
    rx_ready = 1'b1;
    wait_clk(30);
    check("drain all 16", exp_q.size(), 0);
    check("drain level 0", fifo_level, 0);
    check("fill frame_err count", n_frame - f0, 1);

    // Leave a byte stranded, then reset in the middle of bit 4 of 0xF0.
    rx_ready = 1'b0;
    send_byte(8'h5A, 1'b1);
    wait_clk(5);
    check("pre-reset level", fifo_level, 1);
    check("pre-reset rx_valid", rx_valid, 1);
    line = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 4; i++) begin
      line = 1'b0;
      wait_clk(16);
    end
    line = 1'b1;
    wait_clk(8);
    reset_reset = 1'b1;
    #1;
    check("mid-reset rx_valid", rx_valid, 0);
    check("mid-reset rx_data", rx_data, 0);
    check("mid-reset fifo_level", fifo_level, 0);
    check("mid-reset frame_err", frame_err, 0);
    check("mid-reset overrun_err", overrun_err, 0);
    wait_clk(3);
    reset_reset = 1'b0;
    rx_ready = 1'b1;
    wait_clk(40);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_clk(20);
    check("post-reset drained", exp_q.size(), 0);

`ifdef UART_TAP_RX_PARITY_EN
    // Wrong parity: byte still delivered, parity_err pulses once.
    f0 = n_par;
    bad_par = 1'b1;
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1);
    bad_par = 1'b0;
    wait_clk(20);
    check("parity byte drained", exp_q.size(), 0);
    check("parity_err count", n_par - f0, 1);
`endif

    check("final overrun count", n_ovr - o0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
